nec_ir_tx: RTL
==============

// Module: nec_ir_tx
// PURPOSE
//  NEC infrared transmitter: turns an {address, command} request into a modulated NEC frame on an IR LED pin.
//  It is the transmit end of the NEC link whose receive path enters through the input synchroniser.
//  It is driven from the UART command path via a valid/ready handshake.
//  It also emits NEC repeat codes and enforces the 108 ms NEC frame period.
// PARAMETERS
//  CLK_FREQ_HZ  27_000_000  sys_clk frequency in Hz
//  CARRIER_HZ   38_000      IR carrier frequency in Hz
//  CARRIER_EN   1           1: ir_out = envelope AND carrier; 0: ir_out = envelope (external modulator)
//  Derived: UNIT_CYC = CLK_FREQ_HZ*9/16000 (562.5 us, floor); HALF_CYC = CLK_FREQ_HZ/(2*CARRIER_HZ) (floor)
// PORTS
//  sys_clk     in   1   system clock
//  sys_rst     in   1   reset; synchronous, active-high
//  tx_valid    in   1   request valid
//  tx_ready    out  1   high only in IDLE; request accepted when tx_valid && tx_ready
//  tx_addr     in   16  address; only [7:0] is used when tx_ext=0
//  tx_cmd      in   8   command byte
//  tx_ext      in   1   1: 16-bit extended address; 0: sends addr[7:0], ~addr[7:0]
//  tx_repeat   in   1   1: send a repeat code (addr/cmd ignored)
//  ir_env      out  1   frame envelope, 1 = mark
//  ir_out      out  1   LED drive, active-high
//  busy        out  1   high from the cycle after acceptance until the frame period ends
//  done        out  1   one-cycle pulse at the end of the frame period
// BEHAVIOUR
//  Reset values: tx_ready=1, ir_env=0, ir_out=0, busy=0, done=0, state=IDLE, all counters 0.
//  Reset mid-frame: the next edge forces the reset values; the frame is abandoned and no done pulse is issued.
//  Acceptance (cycle 0): tx_addr/tx_cmd/tx_ext/tx_repeat are latched; input changes after cycle 0 are ignored.
//  Frame timeline starts at cycle 1: ir_env, busy and the unit counter start on the first edge after acceptance.
//  Durations are in units (U) of UNIT_CYC cycles.
//  Data frame: LEAD_MARK 16U -> LEAD_SPACE 8U -> 32 bits -> STOP_MARK 1U -> GAP.
//  Data bit cell: BIT_MARK 1U, then BIT_SPACE 1U for a 0 or 3U for a 1.
//  Bit order: byte0, byte1, cmd, ~cmd; LSB first within each byte.
//    tx_ext=0: byte0 = addr[7:0], byte1 = ~addr[7:0].
//    tx_ext=1: byte0 = addr[7:0], byte1 = addr[15:8].
//  Repeat frame: LEAD_MARK 16U -> REP_SPACE 4U -> STOP_MARK 1U -> GAP.
//  GAP: ir_env=0; ends when 192U (108 ms) have elapsed since cycle 1, regardless of frame content.
//    Longest data frame is 153U, so GAP is always at least 39U long.
//  End of frame: done=1 and busy=1 in cycle 192*UNIT_CYC; IDLE and tx_ready=1 from cycle 192*UNIT_CYC+1.
//  Back-to-back: with tx_valid held high, successive acceptances are exactly 192*UNIT_CYC+1 cycles apart.
//  Carrier:
//    phase counter restarts at the first cycle of every mark; carrier starts high;
//    toggles every HALF_CYC cycles; forced low outside marks.
//  ir_out = ir_env & carrier when CARRIER_EN=1, else ir_out = ir_env.
//  All outputs are registered. No glitches on ir_out at state changes.
//  Widths:
//    unit counter: clog2(UNIT_CYC) bits, wraps to 0 at UNIT_CYC-1;
//    unit tally: 8 bits (max 191);
//    bit index: 5 bits.
// TESTING  (sim params: CLK_FREQ_HZ=160_000, CARRIER_HZ=8_000 -> UNIT_CYC=90, HALF_CYC=10)
//  T1 addr=0x00, cmd=0xA5, ext=0, repeat=0 ->
//     ir_env high cycles 1-1440, low 1441-2160;
//     decoded bits = 0x00, 0xFF, 0xA5, 0x5A (LSB first); 16 ones -> stop mark ends at cycle 121*90=10890;
//     done at 17280; tx_ready at 17281.
//  T2 ext=1, addr=0x1234, cmd=0x10 -> decoded bytes 0x34, 0x12, 0x10, 0xEF; 192U period unchanged.
//  T3 repeat=1 -> ir_env high 1-1440, low 1441-1800, high 1801-1890, low until done at 17280.
//  T4 CARRIER_EN=1 -> in every mark ir_out is high 10, low 10, starting high on the mark's first cycle;
//     ir_out=0 in spaces.
//     CARRIER_EN=0 -> ir_out==ir_env on every cycle.
//  T5 tx_valid held high with changing data during a frame -> frame bits unaffected;
//     second acceptance at cycle 17281; exactly one done per frame.
//  T6 sys_rst for 1 cycle at cycle 3000 (mid-bit) -> next cycle ir_env=ir_out=busy=0, tx_ready=1;
//     no done pulse; a new request transmits cleanly.

Source files
------------

// File: rtl/nec_ir_tx_if.sv
// Request channel into the NEC transmitter: {address, command} plus frame options.
// No latency of its own; it only bundles the request wires.
// The request is held by the master until it sees tx_valid && tx_ready.
interface nec_ir_tx_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_addr;
    logic [7:0]  tx_cmd;
    logic        tx_ext;
    logic        tx_repeat;

    modport master (
        output tx_valid,
        output tx_addr,
        output tx_cmd,
        output tx_ext,
        output tx_repeat,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_addr,
        input  tx_cmd,
        input  tx_ext,
        input  tx_repeat,
        output tx_ready
    );
endinterface

// File: rtl/nec_ir_tx.sv
// NEC IR transmitter: sends a data or repeat frame with an optional 38 kHz carrier.
// The envelope starts 1 cycle after acceptance; the frame period is fixed at 192 units of 562.5 us.
// tx_ready is high only in IDLE, so a request waits until the current frame period has ended.
module nec_ir_tx #(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int CARRIER_HZ  = 38_000,
    parameter bit CARRIER_EN  = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    nec_ir_tx_if.slave  tx,
    output logic        ir_env,
    output logic        ir_out,
    output logic        busy,
    output logic        done
);

    localparam int UNIT_CYC = CLK_FREQ_HZ * 9 / 16000;
    localparam int HALF_CYC = CLK_FREQ_HZ / (2 * CARRIER_HZ);
    localparam int UW       = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int HW       = $clog2(HALF_CYC + 1);

    localparam logic [UW-1:0] U_LAST     = UW'(UNIT_CYC - 1);
    localparam logic [UW-1:0] U_PRE      = UW'(UNIT_CYC - 2);
    localparam logic [HW-1:0] H_LAST     = HW'(HALF_CYC - 1);
    localparam logic [7:0]    TALLY_LAST = 8'd191;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_REP_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } state_t;

    state_t         state;
    logic [UW-1:0]  ucnt;       // cycle within the current unit
    logic [7:0]     utally;     // units elapsed since cycle 1 of the frame
    logic [3:0]     seg_left;   // units left in the current segment, minus one
    logic [4:0]     bidx;       // index of the data bit being sent
    logic [31:0]    shreg;      // frame payload, bit 0 goes out next
    logic           rpt;
    logic           carrier;    // carrier already gated by the envelope
    logic [HW-1:0]  ph;
    logic           ready_q;

    assign tx.tx_ready = ready_q;
    // Both sources are flops, so the pin is glitch-free across state changes.
    assign ir_out = CARRIER_EN ? carrier : ir_env;

    // Frame sequencer: timebase, segment walk, envelope and gated carrier.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            ucnt     <= '0;
            utally   <= '0;
            seg_left <= '0;
            bidx     <= '0;
            shreg    <= '0;
            rpt      <= 1'b0;
            carrier  <= 1'b0;
            ph       <= '0;
            ready_q  <= 1'b1;
            ir_env   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (tx.tx_valid) begin
                    shreg    <= {~tx.tx_cmd, tx.tx_cmd,
                                 (tx.tx_ext ? tx.tx_addr[15:8] : ~tx.tx_addr[7:0]),
                                 tx.tx_addr[7:0]};
                    rpt      <= tx.tx_repeat;
                    state    <= S_LEAD_MARK;
                    seg_left <= 4'd15;
                    bidx     <= '0;
                    ucnt     <= '0;
                    utally   <= '0;
                    ir_env   <= 1'b1;
                    carrier  <= 1'b1;
                    ph       <= '0;
                    busy     <= 1'b1;
                    ready_q  <= 1'b0;
                end
            end else begin
                if (ucnt == U_LAST) begin
                    ucnt   <= '0;
                    utally <= utally + 8'd1;
                end else begin
                    ucnt <= ucnt + UW'(1);
                end

                // done lands on the last cycle of the period, one cycle before IDLE
                if (utally == TALLY_LAST && ucnt == U_PRE)
                    done <= 1'b1;

                if (ir_env) begin
                    if (ph == H_LAST) begin
                        ph      <= '0;
                        carrier <= ~carrier;
                    end else begin
                        ph <= ph + HW'(1);
                    end
                end

                if (utally == TALLY_LAST && ucnt == U_LAST) begin
                    state   <= S_IDLE;
                    utally  <= '0;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    ir_env  <= 1'b0;
                    carrier <= 1'b0;
                end else if (ucnt == U_LAST) begin
                    if (seg_left != 4'd0) begin
                        seg_left <= seg_left - 4'd1;
                    end else begin
                        // Marks never follow marks, so every entry into a mark restarts the carrier.
                        case (state)
                            S_LEAD_MARK: begin
                                state    <= rpt ? S_REP_SPACE : S_LEAD_SPACE;
                                seg_left <= rpt ? 4'd3 : 4'd7;
                                ir_env   <= 1'b0;
                                carrier  <= 1'b0;
                            end
                            S_LEAD_SPACE, S_REP_SPACE: begin
                                state    <= (state == S_REP_SPACE) ? S_STOP_MARK : S_BIT_MARK;
                                seg_left <= 4'd0;
                                ir_env   <= 1'b1;
                                carrier  <= 1'b1;
                                ph       <= '0;
                            end
                            S_BIT_MARK: begin
                                state    <= S_BIT_SPACE;
                                seg_left <= shreg[0] ? 4'd2 : 4'd0;
                                ir_env   <= 1'b0;
                                carrier  <= 1'b0;
                            end
                            S_BIT_SPACE: begin
                                state    <= (bidx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                                seg_left <= 4'd0;
                                bidx     <= bidx + 5'd1;
                                shreg    <= shreg >> 1;
                                ir_env   <= 1'b1;
                                carrier  <= 1'b1;
                                ph       <= '0;
                            end
                            S_STOP_MARK: begin
                                state   <= S_GAP;
                                ir_env  <= 1'b0;
                                carrier <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule
